// File: rtl/axis_testpattern_checker.sv
// ============================================================================
// axis_testpattern_checker
// AXI-Stream sink that locks onto the wrapping counter stream of the test-pattern
// generator and checks each further beat. Optional first-error capture is
// enabled by defining AXIS_TPCHK_FIRSTERR_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axis_testpattern_checker #(
   parameter int S00_AXIS_TDATA_WIDTH = 32,
   parameter int COUNTER_START        = 0,
   parameter int COUNTER_END          = 255,
   parameter int COUNTER_INCR         = 1,
   parameter int LOCK_COUNT           = 4,
   parameter int ERR_CNT_WIDTH        = 16
) (
   input  logic                            s_axis_aclk,
   input  logic                            s_axis_aresetn,
   input  logic                            enable,
   input  logic                            clear,
   input  logic [S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic                            s_axis_tvalid,
   output logic                            s_axis_tready,
   output logic                            locked,
   output logic                            error,
   output logic [ERR_CNT_WIDTH-1:0]        err_count,
   output logic [31:0]                     word_count,
   output logic [S00_AXIS_TDATA_WIDTH-1:0] first_err_exp,
   output logic [S00_AXIS_TDATA_WIDTH-1:0] first_err_got
);

   localparam int W = S00_AXIS_TDATA_WIDTH;
   localparam logic [W-1:0] C_END  = W'(COUNTER_END);
   localparam logic [W-1:0] C_SPAN = W'(COUNTER_END - COUNTER_START);
   localparam logic [W-1:0] C_INCR = W'(COUNTER_INCR);
   localparam logic [8:0]   C_LOCK = 9'(LOCK_COUNT);

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      LOCKING = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   // Successor of a counter value, including the wrap back to COUNTER_START.
   function automatic logic [W-1:0] next_val(input logic [W-1:0] v);
      if (v >= C_END) begin
         return v - C_SPAN;
      end
      return v + C_INCR;
   endfunction

   state_t                   state_q, state_d;
   logic [W-1:0]             expected_q, expected_d;
   logic [7:0]               match_cnt_q, match_cnt_d;
   logic                     tready_q;
   logic                     error_q, error_d;
   logic [ERR_CNT_WIDTH-1:0] err_count_q, err_count_d;
   logic [31:0]              word_count_q, word_count_d;

   logic       accept;
   logic       is_match;
   logic [8:0] match_inc;
   logic       lock_err;

   assign accept    = s_axis_tvalid & tready_q;
   assign is_match  = (s_axis_tdata == expected_q);
   assign match_inc = {1'b0, match_cnt_q} + 9'd1;
   assign lock_err  = accept & ~clear & (state_q == LOCKED) & ~is_match;

   always_comb begin
      state_d      = state_q;
      expected_d   = expected_q;
      match_cnt_d  = match_cnt_q;
      error_d      = 1'b0;
      err_count_d  = err_count_q;
      word_count_d = word_count_q;
      if (clear) begin
         state_d      = HUNT;
         match_cnt_d  = 8'd0;
         err_count_d  = '0;
         word_count_d = 32'd0;
      end else if (accept) begin
         word_count_d = word_count_q + 32'd1;
         expected_d   = next_val(s_axis_tdata);
         case (state_q)
            HUNT: begin
               match_cnt_d = 8'd1;
               state_d     = LOCKING;
            end
            LOCKING: begin
               if (is_match) begin
                  match_cnt_d = match_inc[7:0];
                  if (match_inc == C_LOCK) begin
                     state_d = LOCKED;
                  end
               end else begin
                  match_cnt_d = 8'd1;
               end
            end
            LOCKED: begin
               if (!is_match) begin
                  error_d     = 1'b1;
                  match_cnt_d = 8'd1;
                  state_d     = LOCKING;
                  if (!(&err_count_q)) begin
                     err_count_d = err_count_q + 1'b1;
                  end
               end
            end
            default: begin
               state_d     = HUNT;
               match_cnt_d = 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         state_q      <= HUNT;
         expected_q   <= '0;
         match_cnt_q  <= 8'd0;
         tready_q     <= 1'b0;
         error_q      <= 1'b0;
         err_count_q  <= '0;
         word_count_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         expected_q   <= expected_d;
         match_cnt_q  <= match_cnt_d;
         tready_q     <= enable;
         error_q      <= error_d;
         err_count_q  <= err_count_d;
         word_count_q <= word_count_d;
      end
   end

   assign s_axis_tready = tready_q;
   assign locked        = (state_q == LOCKED);
   assign error         = error_q;
   assign err_count     = err_count_q;
   assign word_count    = word_count_q;

`ifdef AXIS_TPCHK_FIRSTERR_EN
   logic         first_seen_q, first_seen_d;
   logic [W-1:0] first_exp_q, first_exp_d;
   logic [W-1:0] first_got_q, first_got_d;

   // Only the first LOCKED mismatch since reset/clear is retained.
   always_comb begin
      first_seen_d = first_seen_q;
      first_exp_d  = first_exp_q;
      first_got_d  = first_got_q;
      if (clear) begin
         first_seen_d = 1'b0;
         first_exp_d  = '0;
         first_got_d  = '0;
      end else if (lock_err && !first_seen_q) begin
         first_seen_d = 1'b1;
         first_exp_d  = expected_q;
         first_got_d  = s_axis_tdata;
      end
   end

   always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
      if (!s_axis_aresetn) begin
         first_seen_q <= 1'b0;
         first_exp_q  <= '0;
         first_got_q  <= '0;
      end else begin
         first_seen_q <= first_seen_d;
         first_exp_q  <= first_exp_d;
         first_got_q  <= first_got_d;
      end
   end

   assign first_err_exp = first_exp_q;
   assign first_err_got = first_got_q;
`else
   logic unused_lock_err;
   assign unused_lock_err = lock_err;
   assign first_err_exp   = '0;
   assign first_err_got   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axis_testpattern_checker.sv
// ============================================================================
// tb_axis_testpattern_checker
// Directed bench for axis_testpattern_checker; a second instance with a 2-bit
// error counter shares the stimulus to exercise saturation.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axis_testpattern_checker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        clear;
   logic [31:0] tdata;
   logic        tvalid;

   logic        tready_a, locked_a, error_a;
   logic [15:0] errc_a;
   logic [31:0] wc_a, fexp_a, fgot_a;
   logic        tready_b, locked_b, error_b;
   logic [1:0]  errc_b;
   logic [31:0] wc_b, fexp_b, fgot_b;

   int total = 0;
   int bad   = 0;
   int wcnt  = 0;

   always #5 clk = ~clk;

   axis_testpattern_checker dut (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .enable(enable), .clear(clear),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_a),
      .locked(locked_a), .error(error_a), .err_count(errc_a), .word_count(wc_a),
      .first_err_exp(fexp_a), .first_err_got(fgot_a)
   );

   axis_testpattern_checker #(.ERR_CNT_WIDTH(2)) dut_sat (
      .s_axis_aclk(clk), .s_axis_aresetn(rst_n), .enable(enable), .clear(clear),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_b),
      .locked(locked_b), .error(error_b), .err_count(errc_b), .word_count(wc_b),
      .first_err_exp(fexp_b), .first_err_got(fgot_b)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One accepted beat; outputs sampled 1 time unit after the edge.
   task automatic beat(input logic [31:0] v);
      tdata  = v;
      tvalid = 1'b1;
      @(posedge clk);
      #1;
      wcnt++;
   endtask

   task automatic chk_first(input logic [31:0] e, input logic [31:0] g);
`ifdef AXIS_TPCHK_FIRSTERR_EN
      chk("first_err_exp", fexp_a, e);
      chk("first_err_got", fgot_a, g);
`else
      chk("first_err_exp_tied", fexp_a, 0);
      chk("first_err_got_tied", fgot_a, 0);
      if (e != g) chk("first_err_unused", 0, 0);
`endif
   endtask

   initial begin
      int errs;
      rst_n  = 1'b0;
      enable = 1'b0;
      clear  = 1'b0;
      tdata  = 32'd0;
      tvalid = 1'b0;
      #23;
      chk("rst_tready", tready_a, 0);
      chk("rst_locked", locked_a, 0);
      chk("rst_error", error_a, 0);
      chk("rst_errc", errc_a, 0);
      chk("rst_wc", wc_a, 0);
      chk_first(0, 0);

      rst_n  = 1'b1;
      enable = 1'b1;
      @(posedge clk);
      #1;
      chk("tready_follow", tready_a, 1);

      // Lock-up on 0..9: locked after the beat carrying value 3.
      errs = 0;
      for (int v = 0; v < 10; v++) begin
         beat(v);
         chk($sformatf("lock_v%0d", v), locked_a, (v >= 3) ? 1 : 0);
         if (error_a) errs++;
      end
      chk("lock_no_err", errs, 0);
      chk("wc_10", wc_a, 10);

      // A tvalid gap must not disturb anything.
      tvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("gap_locked", locked_a, 1);
      chk("gap_wc", wc_a, 10);

      errs = 0;
      for (int v = 10; v < 250; v++) begin
         beat(v);
         if (error_a || !locked_a) errs++;
      end
      chk("run_clean", errs, 0);

      // Wrap 255 -> 0 is legal.
      for (int v = 250; v < 258; v++) begin
         beat(v & 255);
         if (error_a || !locked_a) errs++;
      end
      chk("wrap_clean", errs, 0);
      chk("wrap_errc", errc_a, 0);
      beat(2); beat(3); beat(4);

      // Inject 7 where 5 is expected.
      beat(7);
      chk("inj_error", error_a, 1);
      chk("inj_locked", locked_a, 0);
      chk("inj_errc", errc_a, 1);
      chk_first(5, 7);
      beat(8);
      chk("inj_pulse_once", error_a, 0);
      chk("inj_unlocked8", locked_a, 0);
      beat(9);
      chk("inj_unlocked9", locked_a, 0);
      beat(10);
      beat(11);
      chk("inj_relocked", locked_a, 1);
      chk("inj_errc_hold", errc_a, 1);

      // 256 after 255 is a mismatch; next(256) wraps to 1.
      for (int v = 12; v < 256; v++) beat(v);
      beat(256);
      chk("w256_error", error_a, 1);
      chk("w256_errc", errc_a, 2);
      chk_first(5, 7);
      beat(1); beat(2); beat(3);
      chk("w256_relock", locked_a, 1);

      // Five more mismatches with relock in between: 2-bit counter saturates.
      for (int k = 0; k < 5; k++) begin
         beat(100);
         if (!error_a) errs++;
         beat(101); beat(102); beat(103);
         if (!locked_a) errs++;
      end
      chk("sat_seq", errs, 0);
      chk("sat_errc16", errc_a, 7);
      chk("sat_errc2", errc_b, 3);
      chk("wc_model", wc_a, wcnt);

      // clear with a simultaneous accepted beat: beat is dropped.
      clear = 1'b1;
      beat(104);
      clear = 1'b0;
      chk("clr_wc", wc_a, 0);
      chk("clr_errc", errc_a, 0);
      chk("clr_locked", locked_a, 0);
      chk("clr_error", error_a, 0);
      chk_first(0, 0);
      beat(50); beat(51); beat(52);
      chk("clr_not_yet", locked_a, 0);
      beat(53);
      chk("clr_relock", locked_a, 1);
      chk("clr_wc4", wc_a, 4);

      beat(60);
      chk("pre_rst_errc", errc_a, 1);
      beat(61); beat(62); beat(63);
      chk("pre_rst_locked", locked_a, 1);

      // Asynchronous reset mid-stream.
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_locked", locked_a, 0);
      chk("arst_tready", tready_a, 0);
      chk("arst_wc", wc_a, 0);
      chk("arst_errc", errc_a, 0);
      #3;
      rst_n = 1'b1;
      tvalid = 1'b0;
      @(posedge clk);
      #1;
      chk("arst_tready_back", tready_a, 1);
      beat(20); beat(21); beat(22);
      chk("arst_not_yet", locked_a, 0);
      beat(23);
      chk("arst_relock", locked_a, 1);
      chk("arst_wc4", wc_a, 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
